// File: rtl/mem_lane_bridge.sv
// Registered bridge between a CPU load/store unit and a byte-addressed Avalon data bus.
// Places bytes on lanes by address, applies endianness, builds byte enables and extends loads.
module mem_lane_bridge #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cpu_req,
    input  logic                cpu_write,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [1:0]          cpu_size,
    input  logic                cpu_signed,
    input  logic [DATA_W-1:0]   cpu_wdata,
    output logic                cpu_busy,
    output logic                cpu_ready,
    output logic                cpu_err,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_read,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic [DATA_W-1:0]   mem_writedata,
    input  logic [DATA_W-1:0]   mem_readdata,
    input  logic                mem_waitrequest
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state;
    logic [OFF_W-1:0] off_q;
    logic [1:0]       size_q;
    logic             sext_q;

    logic [OFF_W-1:0]  req_off;
    logic [3:0]        req_bytes;
    logic [2:0]        align_mask;
    logic              req_bad;
    logic [OFF_W-1:0]  req_src;
    logic [NB-1:0]     req_be;
    logic [DATA_W-1:0] req_wdata;

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        req_off    = cpu_addr[OFF_W-1:0];
        req_bytes  = 4'd1 << cpu_size;
        align_mask = 3'(req_bytes - 4'd1);
        req_bad    = (|(cpu_addr[2:0] & align_mask)) || (req_bytes > 4'(NB));
        req_src    = '0;
        req_be     = '0;
        req_wdata  = '0;
        for (int k = 0; k < NB; k++) begin
            if (k >= int'(req_off) && k < int'(req_off) + int'(req_bytes)) begin
                // Lane k carries access byte (k - offset); pick the value byte it holds.
                req_src = OFF_W'(BIG_ENDIAN ? int'(req_bytes) - 1 - (k - int'(req_off))
                                            : k - int'(req_off));
                req_be[k]           = 1'b1;
                req_wdata[8*k +: 8] = cpu_wdata[{req_src, 3'b000} +: 8];
            end
        end
    end

    logic [3:0]        ld_bytes;
    logic [OFF_W-1:0]  ld_lane;
    logic              ld_sign;
    logic [DATA_W-1:0] ld_value;

    always_comb begin
        ld_bytes = 4'd1 << size_q;
        ld_lane  = '0;
        ld_sign  = 1'b0;
        ld_value = '0;
        for (int j = 0; j < NB; j++) begin
            if (j < int'(ld_bytes)) begin
                ld_lane            = OFF_W'(int'(off_q) + (BIG_ENDIAN ? int'(ld_bytes) - 1 - j : j));
                ld_value[8*j +: 8] = mem_readdata[{ld_lane, 3'b000} +: 8];
                ld_sign            = mem_readdata[{ld_lane, 3'b111}];
            end
        end
        for (int j = 0; j < NB; j++) begin
            if (j >= int'(ld_bytes)) begin
                ld_value[8*j +: 8] = {8{sext_q & ld_sign}};
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register updates together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            off_q          <= '0;
            size_q         <= '0;
            sext_q         <= 1'b0;
            cpu_busy       <= 1'b0;
            cpu_ready      <= 1'b0;
            cpu_err        <= 1'b0;
            cpu_rdata      <= '0;
            mem_address    <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_byteenable <= '0;
            mem_writedata  <= '0;
        end else begin
            cpu_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        cpu_busy <= 1'b1;
                        if (req_bad) begin
                            state     <= ST_RESP;
                            cpu_ready <= 1'b1;
                            cpu_err   <= 1'b1;
                        end else begin
                            state          <= ST_BUS;
                            off_q          <= req_off;
                            size_q         <= cpu_size;
                            sext_q         <= cpu_signed;
                            mem_address    <= {cpu_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            mem_read       <= ~cpu_write;
                            mem_write      <= cpu_write;
                            mem_byteenable <= req_be;
                            mem_writedata  <= req_wdata;
                        end
                    end
                end
                ST_BUS: begin
                    if (!mem_waitrequest) begin
                        if (mem_read) begin
                            cpu_rdata <= ld_value;
                        end
                        state          <= ST_RESP;
                        cpu_ready      <= 1'b1;
                        cpu_err        <= 1'b0;
                        mem_read       <= 1'b0;
                        mem_write      <= 1'b0;
                        mem_byteenable <= '0;
                        mem_writedata  <= '0;
                    end
                end
                ST_RESP: begin
                    state    <= ST_IDLE;
                    cpu_busy <= 1'b0;
                    cpu_err  <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    cpu_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
